compute_wrapper: RTL and testbench



---
 rtl/compute_wrapper.sv | 119 +++++++++++
 tb/tb_compute_wrapper.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/compute_wrapper.sv
// compute_wrapper: loads A and B vectors from AXI-Stream inputs and streams running dot-product results on C.
module compute_wrapper #(
    parameter int DATA_W = 32,
    parameter int K_MAX  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_a_tdata,
    input  logic              s_axis_a_tvalid,
    output logic              s_axis_a_tready,
    input  logic              s_axis_a_tlast,
    input  logic [DATA_W-1:0] s_axis_b_tdata,
    input  logic              s_axis_b_tvalid,
    output logic              s_axis_b_tready,
    input  logic              s_axis_b_tlast,
    output logic [DATA_W-1:0] m_axis_c_tdata,
    output logic              m_axis_c_tvalid,
    input  logic              m_axis_c_tready,
    output logic              m_axis_c_tlast,
    input  logic [15:0]       cfg_k,
    input  logic              start,
    output logic              done
);
    localparam int IW = $clog2(K_MAX + 1);
    localparam int AW = $clog2(K_MAX);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, OUTPUT, DONE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     k_q, k_d, idx_q, idx_d, idx_inc, k_lat;
    logic [DATA_W-1:0] acc_q, acc_d, c_sum;
    logic [DATA_W-1:0] a_q [K_MAX];
    logic [DATA_W-1:0] b_q [K_MAX];
    logic [AW-1:0]     addr;
    logic              done_q, done_d, done_pulse, clr;
    logic              a_hs, b_hs, c_hs;
    logic              sw_clear_done;

    assign addr            = idx_q[AW-1:0];
    assign idx_inc         = idx_q + IW'(1);
    assign k_lat           = (cfg_k == 16'd0) ? IW'(1) : (cfg_k > 16'(K_MAX)) ? IW'(K_MAX) : cfg_k[IW-1:0];
    assign c_sum           = acc_q + a_q[addr] * b_q[addr];
    assign s_axis_a_tready = (state_q == LOAD_A);
    assign s_axis_b_tready = (state_q == LOAD_B);
    assign m_axis_c_tvalid = (state_q == OUTPUT);
    assign m_axis_c_tdata  = m_axis_c_tvalid ? c_sum : '0;
    assign m_axis_c_tlast  = m_axis_c_tvalid && (idx_inc == k_q);
    assign a_hs            = s_axis_a_tready && s_axis_a_tvalid;
    assign b_hs            = s_axis_b_tready && s_axis_b_tvalid;
    assign c_hs            = m_axis_c_tvalid && m_axis_c_tready;
    assign done            = done_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        clr     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                k_d     = k_lat;
                idx_d   = '0;
                clr     = 1'b1;
                state_d = LOAD_A;
            end
            LOAD_A: if (a_hs) begin
                idx_d   = (s_axis_a_tlast || idx_inc == k_q) ? '0 : idx_inc;
                state_d = (s_axis_a_tlast || idx_inc == k_q) ? LOAD_B : LOAD_A;
            end
            LOAD_B: if (b_hs) begin
                idx_d   = (s_axis_b_tlast || idx_inc == k_q) ? '0 : idx_inc;
                state_d = (s_axis_b_tlast || idx_inc == k_q) ? COMPUTE : LOAD_B;
            end
            COMPUTE: begin
                acc_d   = '0;
                idx_d   = '0;
                state_d = OUTPUT;
            end
            OUTPUT: if (c_hs) begin
                acc_d   = c_sum;
                idx_d   = idx_inc;
                state_d = m_axis_c_tlast ? DONE : OUTPUT;
            end
            default: state_d = IDLE;
        endcase
        // a simultaneous set and clear resolves to set
        done_d = done_pulse ? 1'b1 : (sw_clear_done || (state_q == IDLE && start)) ? 1'b0 : done_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            done_q     <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            done_q     <= done_d;
            done_pulse <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < K_MAX; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            if (a_hs) a_q[addr] <= s_axis_a_tdata;
            if (b_hs) b_q[addr] <= s_axis_b_tdata;
        end
    end
endmodule

// File: tb/tb_compute_wrapper.sv
// tb_compute_wrapper: directed scenarios for compute_wrapper with hand-computed expectations.
module tb_compute_wrapper;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_axis_a_tdata, s_axis_b_tdata, m_axis_c_tdata;
    logic        s_axis_a_tvalid, s_axis_a_tready, s_axis_a_tlast;
    logic        s_axis_b_tvalid, s_axis_b_tready, s_axis_b_tlast;
    logic        m_axis_c_tvalid, m_axis_c_tready, m_axis_c_tlast;
    logic [15:0] cfg_k;
    logic        start, done;
    int          n_checks = 0;
    int          n_fail = 0;

    compute_wrapper dut (
        .clk(clk), .rst(rst),
        .s_axis_a_tdata(s_axis_a_tdata), .s_axis_a_tvalid(s_axis_a_tvalid),
        .s_axis_a_tready(s_axis_a_tready), .s_axis_a_tlast(s_axis_a_tlast),
        .s_axis_b_tdata(s_axis_b_tdata), .s_axis_b_tvalid(s_axis_b_tvalid),
        .s_axis_b_tready(s_axis_b_tready), .s_axis_b_tlast(s_axis_b_tlast),
        .m_axis_c_tdata(m_axis_c_tdata), .m_axis_c_tvalid(m_axis_c_tvalid),
        .m_axis_c_tready(m_axis_c_tready), .m_axis_c_tlast(m_axis_c_tlast),
        .cfg_k(cfg_k), .start(start), .done(done)
    );

    always #5 clk = ~clk;

    task automatic do_start(input logic [15:0] k);
        cfg_k = k;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input bit is_b, input logic [31:0] d[$], input bit use_last, output bit tmo);
        tmo = 1'b0;
        for (int i = 0; i < d.size(); i++) begin
            int t = 0;
            if (is_b) begin
                s_axis_b_tdata = d[i]; s_axis_b_tvalid = 1'b1; s_axis_b_tlast = use_last && (i == d.size() - 1);
            end else begin
                s_axis_a_tdata = d[i]; s_axis_a_tvalid = 1'b1; s_axis_a_tlast = use_last && (i == d.size() - 1);
            end
            while (!(is_b ? s_axis_b_tready : s_axis_a_tready) && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 50) begin
                tmo = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        s_axis_a_tvalid = 1'b0; s_axis_a_tlast = 1'b0;
        s_axis_b_tvalid = 1'b0; s_axis_b_tlast = 1'b0;
    endtask

    task automatic collect(input bit rnd, output logic [31:0] data[$], output bit lasts[$],
                           output int pulses, output bit tmo);
        data = {}; lasts = {}; pulses = 0; tmo = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            m_axis_c_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_axis_c_tvalid && m_axis_c_tready) begin
                data.push_back(m_axis_c_tdata);
                lasts.push_back(m_axis_c_tlast);
            end
            @(posedge clk); #1;
            if (lasts.size() > 0 && lasts[lasts.size() - 1]) begin
                tmo = 1'b0;
                break;
            end
        end
        m_axis_c_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (dut.done_pulse) pulses++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({s_axis_a_tready, s_axis_b_tready, m_axis_c_tvalid, m_axis_c_tlast} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_handshake got %b want 0000", {s_axis_a_tready, s_axis_b_tready, m_axis_c_tvalid, m_axis_c_tlast});
        end
        n_checks++;
        if (m_axis_c_tdata !== 32'd0) begin n_fail++; $display("FAIL reset_tdata got %h want 0", m_axis_c_tdata); end
        n_checks++;
        if ({done, dut.done_pulse} !== 2'b00) begin n_fail++; $display("FAIL reset_done got %b want 00", {done, dut.done_pulse}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] q[$], data[$];
        bit lasts[$];
        bit tmo_a, tmo_b, tmo_c;
        int pulses, bad = 0, lastpos = -1, nlast = 0;
        do_start(16'd4);
        q = {32'h0000_000A}; send(1'b0, q, 1'b1, tmo_a);
        q = {32'h0000_000B}; send(1'b1, q, 1'b1, tmo_b);
        collect(1'b1, data, lasts, pulses, tmo_c);
        n_checks++;
        if ({tmo_a, tmo_b, tmo_c} !== 3'b000) begin n_fail++; $display("FAIL basic_timeout got %b want 000", {tmo_a, tmo_b, tmo_c}); end
        n_checks++;
        if (data.size() !== 4) begin n_fail++; $display("FAIL basic_beats got %0d want 4", data.size()); end
        foreach (data[i]) begin
            if (data[i] !== 32'h6E) bad++;
            if (lasts[i]) begin lastpos = i; nlast++; end
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL basic_data got %0d wrong beats want 0 (each 6e)", bad); end
        n_checks++;
        if (nlast !== 1 || lastpos !== 3) begin n_fail++; $display("FAIL basic_tlast got %0d at %0d want 1 at 3", nlast, lastpos); end
        n_checks++;
        if (pulses !== 1) begin n_fail++; $display("FAIL basic_pulse got %0d want 1", pulses); end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %b want 1", done); end
    endtask

    task automatic test_done_hold();
        int bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b1 || dut.done_pulse !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL done_hold got %0d bad cycles want 0", bad); end
        n_checks++;
        if (s_axis_a_tready !== 1'b0) begin n_fail++; $display("FAIL idle_a_tready got %b want 0", s_axis_a_tready); end
        dut.sw_clear_done = 1'b1;
        @(posedge clk); #1;
        dut.sw_clear_done = 1'b0;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL sw_clear got %b want 0", done); end
    endtask

    task automatic test_vectors();
        logic [31:0] q[$], data[$];
        bit lasts[$];
        bit tmo_a, tmo_b, tmo_c;
        int pulses;
        logic v0, v1;
        do_start(16'd3);
        q = {32'd1, 32'd2, 32'd3}; send(1'b0, q, 1'b0, tmo_a);
        q = {32'd4, 32'd5, 32'd6}; send(1'b1, q, 1'b0, tmo_b);
        v0 = m_axis_c_tvalid;
        @(posedge clk); #1;
        v1 = m_axis_c_tvalid;
        n_checks++;
        if ({v0, v1} !== 2'b01) begin n_fail++; $display("FAIL latency got %b want 01", {v0, v1}); end
        collect(1'b0, data, lasts, pulses, tmo_c);
        n_checks++;
        if ({tmo_a, tmo_b, tmo_c} !== 3'b000) begin n_fail++; $display("FAIL vec_timeout got %b want 000", {tmo_a, tmo_b, tmo_c}); end
        n_checks++;
        if (data.size() !== 3 || data[0] !== 32'd4 || data[1] !== 32'd14 || data[2] !== 32'd32) begin
            n_fail++; $display("FAIL vec_data got %p want 4 14 32", data);
        end
        n_checks++;
        if (lasts.size() !== 3 || lasts[0] || lasts[1] || !lasts[2]) begin n_fail++; $display("FAIL vec_tlast got %p want 0 0 1", lasts); end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL vec_done got %b want 1", done); end
    endtask

    task automatic test_backpressure();
        logic [31:0] q[$], data[$];
        bit lasts[$];
        bit tmo_a, tmo_b, tmo_c;
        int pulses, t = 0, bad = 0;
        logic [33:0] snap;
        do_start(16'd3);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL start_clears_done got %b want 0", done); end
        q = {32'd2, 32'd3, 32'd4}; send(1'b0, q, 1'b1, tmo_a);
        q = {32'd5, 32'd6, 32'd7}; send(1'b1, q, 1'b1, tmo_b);
        m_axis_c_tready = 1'b0;
        while (!m_axis_c_tvalid && t < 20) begin @(posedge clk); #1; t++; end
        snap = {m_axis_c_tvalid, m_axis_c_tlast, m_axis_c_tdata};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if ({m_axis_c_tvalid, m_axis_c_tlast, m_axis_c_tdata} !== snap) bad++;
        end
        n_checks++;
        if (bad !== 0 || snap !== {2'b10, 32'd10}) begin n_fail++; $display("FAIL hold_stable got %0d changes first %h want 0 and 20000000a", bad, snap); end
        collect(1'b1, data, lasts, pulses, tmo_c);
        n_checks++;
        if (tmo_c || data.size() !== 3 || data[0] !== 32'd10 || data[1] !== 32'd28 || data[2] !== 32'd56) begin
            n_fail++; $display("FAIL hold_data got %p want 10 28 56", data);
        end
        n_checks++;
        if ({tmo_a, tmo_b, pulses[1:0]} !== 4'b0001) begin n_fail++; $display("FAIL hold_misc got %b want 0001", {tmo_a, tmo_b, pulses[1:0]}); end
    endtask

    task automatic test_k_bounds();
        logic [31:0] qa[$], qb[$], data[$];
        bit lasts[$];
        bit tmo_a, tmo_b, tmo_c;
        int pulses, bad = 0, nlast = 0;
        do_start(16'd0);
        qa = {32'd7}; send(1'b0, qa, 1'b0, tmo_a);
        n_checks++;
        if (s_axis_a_tready !== 1'b0 || s_axis_b_tready !== 1'b1) begin
            n_fail++; $display("FAIL k0_segment got a=%b b=%b want a=0 b=1", s_axis_a_tready, s_axis_b_tready);
        end
        qb = {32'd9}; send(1'b1, qb, 1'b0, tmo_b);
        collect(1'b0, data, lasts, pulses, tmo_c);
        n_checks++;
        if (tmo_c || data.size() !== 1 || data[0] !== 32'd63 || !lasts[0]) begin n_fail++; $display("FAIL k0_data got %p want 63", data); end
        qa = {}; qb = {};
        for (int i = 0; i < 64; i++) begin qa.push_back(32'(i + 1)); qb.push_back(32'd1); end
        do_start(16'd100);
        send(1'b0, qa, 1'b0, tmo_a);
        n_checks++;
        if (s_axis_a_tready !== 1'b0 || tmo_a) begin n_fail++; $display("FAIL k100_a_clamp got tready=%b want 0", s_axis_a_tready); end
        send(1'b1, qb, 1'b0, tmo_b);
        collect(1'b0, data, lasts, pulses, tmo_c);
        foreach (data[i]) begin
            if (data[i] !== 32'((i + 1) * (i + 2) / 2)) bad++;
            if (lasts[i]) nlast++;
        end
        n_checks++;
        if (tmo_c || data.size() !== 64 || bad !== 0) begin n_fail++; $display("FAIL k100_data got %0d beats %0d wrong want 64 0", data.size(), bad); end
        n_checks++;
        if (nlast !== 1 || !lasts[lasts.size() - 1] || data[data.size() - 1] !== 32'd2080) begin
            n_fail++; $display("FAIL k100_tlast got %0d lasts final %0d want 1 final 2080", nlast, data[data.size() - 1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] q[$], data[$];
        bit lasts[$];
        bit tmo_a, tmo_b, tmo_c;
        int pulses, t = 0;
        do_start(16'd4);
        q = {32'd1, 32'd1, 32'd1, 32'd1}; send(1'b0, q, 1'b0, tmo_a); send(1'b1, q, 1'b0, tmo_b);
        m_axis_c_tready = 1'b1;
        while (!m_axis_c_tvalid && t < 20) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        m_axis_c_tready = 1'b0;
        n_checks++;
        if (m_axis_c_tvalid !== 1'b1 || m_axis_c_tdata !== 32'd2) begin n_fail++; $display("FAIL mid_output got v=%b d=%0d want 1 2", m_axis_c_tvalid, m_axis_c_tdata); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({m_axis_c_tvalid, m_axis_c_tlast, s_axis_a_tready, s_axis_b_tready, done, dut.done_pulse} !== 6'b0 || m_axis_c_tdata !== 32'd0) begin
            n_fail++; $display("FAIL mid_reset got %b %h want 000000 0", {m_axis_c_tvalid, m_axis_c_tlast, s_axis_a_tready, s_axis_b_tready, done, dut.done_pulse}, m_axis_c_tdata);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        do_start(16'd2);
        q = {32'd3, 32'd4}; send(1'b0, q, 1'b1, tmo_a);
        q = {32'd5, 32'd6}; send(1'b1, q, 1'b1, tmo_b);
        collect(1'b1, data, lasts, pulses, tmo_c);
        n_checks++;
        if (tmo_c || data.size() !== 2 || data[0] !== 32'd15 || data[1] !== 32'd39 || pulses !== 1 || done !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_run got %p pulses %0d done %b want 15 39 1 1", data, pulses, done);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_k = '0;
        s_axis_a_tdata = '0; s_axis_a_tvalid = 1'b0; s_axis_a_tlast = 1'b0;
        s_axis_b_tdata = '0; s_axis_b_tvalid = 1'b0; s_axis_b_tlast = 1'b0;
        m_axis_c_tready = 1'b0;
        dut.sw_clear_done = 1'b0;
        test_reset();
        test_basic();
        test_done_hold();
        test_vectors();
        test_backpressure();
        test_k_bounds();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
